// File: rtl/par_serial_gen.sv
// Parametrised parallel-to-serial transmitter: input FIFO, idle-symbol fill,
// link-enable FSM with sync preamble, selectable bit order, sticky overflow.
module par_serial_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(8'hBC),
    parameter int               FIFO_DEPTH = 4,
    parameter int               SYNC_SYMS  = 2,
    parameter int               MSB_FIRST  = 1
) (
    input  logic                            clk_8f,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [WIDTH-1:0]                data_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic                            data_out,
    output logic                            word_start,
    output logic                            sending_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam int SW = $clog2(SYNC_SYMS + 1);

    typedef enum logic [1:0] {DISABLED, SYNC, ACTIVE} state_t;

    state_t           state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [SW-1:0]    sync_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             data_out_q;
    logic             word_start_q;
    logic             sending_q;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;

    logic             push;
    logic             pop;
    logic             boundary;
    logic             go_active;
    logic [WIDTH-1:0] next_sym_d;

    function automatic logic first_bit(input logic [WIDTH-1:0] s);
        return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_sym(input logic [WIDTH-1:0] s);
        return (MSB_FIRST != 0) ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
    endfunction

    assign ready_out    = (count_q < CW'(FIFO_DEPTH));
    assign push         = valid_in && ready_out;
    assign boundary     = (state_q == DISABLED) ? enable : (bit_cnt_q == BW'(WIDTH - 1));
    // The boundary that ends the preamble already uses the ACTIVE selection rule.
    assign go_active    = (state_q == ACTIVE) ||
                          ((state_q == SYNC) && (sync_cnt_q == SW'(SYNC_SYMS)));
    assign pop          = boundary && (state_q != DISABLED) && enable && go_active &&
                          (count_q != '0);
    assign next_sym_d   = pop ? mem_q[rd_ptr_q] : IDLE_SYM;

    assign data_out     = data_out_q;
    assign word_start   = word_start_q;
    assign sending_data = sending_q;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q      <= DISABLED;
            bit_cnt_q    <= '0;
            sync_cnt_q   <= '0;
            data_out_q   <= 1'b0;
            word_start_q <= 1'b0;
            sending_q    <= 1'b0;
        end else begin
            word_start_q <= 1'b0;
            if (boundary) begin
                bit_cnt_q <= '0;
                if ((state_q != DISABLED) && !enable) begin
                    state_q    <= DISABLED;
                    data_out_q <= 1'b0;
                    sending_q  <= 1'b0;
                end else begin
                    shift_q      <= shift_sym(next_sym_d);
                    data_out_q   <= first_bit(next_sym_d);
                    word_start_q <= 1'b1;
                    sending_q    <= pop;
                    if (state_q == DISABLED) begin
                        state_q    <= SYNC;
                        sync_cnt_q <= SW'(1);
                    end else if (go_active) begin
                        state_q <= ACTIVE;
                    end else begin
                        sync_cnt_q <= sync_cnt_q + SW'(1);
                    end
                end
            end else if (state_q != DISABLED) begin
                bit_cnt_q  <= bit_cnt_q + BW'(1);
                data_out_q <= first_bit(shift_q);
                shift_q    <= shift_sym(shift_q);
            end
        end
    end

    // FIFO storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk_8f) begin
        if (!reset && push)
            mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (valid_in && !ready_out)
                overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_par_serial_gen.sv
// Directed bench for par_serial_gen: an MSB-first instance for most scenarios
// and an LSB-first instance for the bit-order variant.
module tb_par_serial_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable, valid_in;
    logic [7:0] data_in;
    logic       ready_out, data_out, word_start, sending_data, overflow;
    logic [2:0] fifo_count;

    logic       enable_b, valid_b;
    logic [7:0] data_b;
    logic       ready_b, data_out_b, word_start_b, sending_b, overflow_b;
    logic [2:0] fifo_count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par_serial_gen dut (
        .clk_8f(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
        .word_start(word_start), .sending_data(sending_data),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    par_serial_gen #(.MSB_FIRST(0)) dut_lsb (
        .clk_8f(clk), .reset(reset), .enable(enable_b), .data_in(data_b),
        .valid_in(valid_b), .ready_out(ready_b), .data_out(data_out_b),
        .word_start(word_start_b), .sending_data(sending_b),
        .fifo_count(fifo_count_b), .overflow(overflow_b)
    );

    // Waits (bounded) for the next word_start and records the 8 line bits in
    // transmission order (first bit ends up in line[7]); optionally pushes one word
    // during the first bit of that symbol.
    task automatic get_sym(input bit sel, input bit push_en, input logic [7:0] pd,
                           output logic [7:0] line, output bit sd_all, output bit sd_any,
                           output bit ws_bad, output bit timeout, output int maxcnt);
        logic b, sd;
        timeout = 1'b1;
        line = 8'h00; sd_all = 1'b1; sd_any = 1'b0; ws_bad = 1'b0; maxcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel ? word_start_b : word_start) === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        if (timeout) return;
        if (push_en) begin
            if (sel) begin data_b = pd; valid_b = 1'b1; end
            else begin data_in = pd; valid_in = 1'b1; end
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (i == 1) begin valid_in = 1'b0; valid_b = 1'b0; end
                if ((sel ? word_start_b : word_start) !== 1'b0) ws_bad = 1'b1;
            end
            b  = sel ? data_out_b : data_out;
            sd = sel ? sending_b : sending_data;
            line = {line[6:0], b};
            if (sd !== 1'b1) sd_all = 1'b0;
            if (sd !== 1'b0) sd_any = 1'b1;
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
    endtask

    task automatic wait_ws(output bit timeout);
        timeout = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (word_start === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; valid_in = 1'b1; data_in = 8'h55;
        enable_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({data_out, word_start, sending_data, overflow} !== 4'b0000 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: dout/ws/sd/ovf=%b%b%b%b cnt=%0d, required 0000 cnt=0",
                     data_out, word_start, sending_data, overflow, fifo_count);
        end
        reset = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || fifo_count !== 3'd0 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b cnt=%0d dout=%b, required ready=1 cnt=0 dout=0",
                     ready_out, fifo_count, data_out);
        end
    endtask

    task automatic test_idle_sync;
        logic [7:0] l; bit sa, sy, wb, to; int mc;
        enable = 1'b1;
        for (int s = 0; s < 3; s++) begin
            get_sym(1'b0, 1'b0, 8'h00, l, sa, sy, wb, to, mc);
            checks++;
            if (to || l !== 8'hBC || sy || wb) begin
                errors++;
                $display("FAIL idle_sym%0d: line=%h sd=%b ws_bad=%b to=%b, required line=bc sd=0",
                         s, l, sy, wb, to);
            end
        end
    endtask

    task automatic test_data;
        logic [7:0] l; bit sa, sy, wb, to; int mc;
        logic [7:0] exp_l [5] = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'hBC};
        bit         exp_d [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 5; s++) begin
            get_sym(1'b0, s < 3, 8'(s + 1), l, sa, sy, wb, to, mc);
            checks++;
            if (to || l !== exp_l[s] || (exp_d[s] ? !sa : sy) || wb) begin
                errors++;
                $display("FAIL data_sym%0d: line=%h sd_all=%b sd_any=%b to=%b, required line=%h sd=%b",
                         s, l, sa, sy, to, exp_l[s], exp_d[s]);
            end
        end
    endtask

    task automatic test_burst;
        logic [7:0] l, e; bit sa, sy, wb, to; int mc, maxc;
        maxc = 0;
        for (int s = 0; s < 12; s++) begin
            get_sym(1'b0, s <= 10, 8'(s), l, sa, sy, wb, to, mc);
            if (mc > maxc) maxc = mc;
            e = (s == 0) ? 8'hBC : 8'(s - 1);
            checks++;
            if (to || l !== e || (s > 0 && !sa)) begin
                errors++;
                $display("FAIL burst_sym%0d: line=%h sd_all=%b to=%b, required line=%h", s, l, sa, to, e);
            end
        end
        checks++;
        if (maxc > 2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_occupancy: max_count=%0d ovf=%b, required max<=2 ovf=0", maxc, overflow);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] l, e; bit sa, sy, wb, to; int mc;
        wait_ws(to);
        for (int k = 0; k < 6; k++) begin
            data_in = 8'hA1 + 8'(k); valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        checks++;
        if (to || fifo_count !== 3'd4 || ready_out !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: cnt=%0d ready=%b ovf=%b to=%b, required cnt=4 ready=0 ovf=1",
                     fifo_count, ready_out, overflow, to);
        end
        for (int s = 0; s < 5; s++) begin
            get_sym(1'b0, 1'b0, 8'h00, l, sa, sy, wb, to, mc);
            e = (s < 4) ? 8'hA1 + 8'(s) : 8'hBC;
            checks++;
            if (to || l !== e) begin
                errors++;
                $display("FAIL overflow_sym%0d: line=%h to=%b, required %h", s, l, to, e);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", overflow);
        end
    endtask

    task automatic test_disable;
        logic [7:0] l, e; bit sa, sy, wb, to, bad; int mc;
        logic [7:0] exp_l [4] = '{8'hBC, 8'hBC, 8'hB2, 8'hB3};
        wait_ws(to);
        for (int k = 0; k < 3; k++) begin
            data_in = 8'hB1 + 8'(k); valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        wait_ws(to);
        l = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            l = {l[6:0], data_out};
            if (i == 3) enable = 1'b0;
        end
        checks++;
        if (to || l !== 8'hB1) begin
            errors++;
            $display("FAIL disable_finish: line=%h to=%b, required b1", l, to);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({data_out, word_start, sending_data} !== 3'b000 || fifo_count !== 3'd2) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL disabled_quiet: dout/ws/sd=%b%b%b cnt=%0d, required 000 cnt=2",
                     data_out, word_start, sending_data, fifo_count);
        end
        enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            get_sym(1'b0, 1'b0, 8'h00, l, sa, sy, wb, to, mc);
            e = exp_l[s];
            checks++;
            if (to || l !== e || (s >= 2 && !sa) || (s < 2 && sy)) begin
                errors++;
                $display("FAIL reenable_sym%0d: line=%h sd_all=%b sd_any=%b to=%b, required %h",
                         s, l, sa, sy, to, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit to, bad;
        wait_ws(to);
        for (int k = 0; k < 2; k++) begin
            data_in = 8'hC1 + 8'(k); valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        wait_ws(to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || fifo_count !== 3'd1 || sending_data !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d sd=%b to=%b, required cnt=1 sd=1", fifo_count, sending_data, to);
        end
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_out, word_start, sending_data, overflow} !== 4'b0000 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: dout/ws/sd/ovf=%b%b%b%b cnt=%0d, required 0000 cnt=0",
                     data_out, word_start, sending_data, overflow, fifo_count);
        end
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ({data_out, word_start} !== 2'b00 || ready_out !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_disabled: dout=%b ws=%b ready=%b, required 0 0 1",
                     data_out, word_start, ready_out);
        end
    endtask

    task automatic test_lsb_first;
        logic [7:0] l, e; bit sa, sy, wb, to; int mc;
        enable_b = 1'b1;
        for (int s = 0; s < 5; s++) begin
            get_sym(1'b1, s == 2, 8'h01, l, sa, sy, wb, to, mc);
            e = (s == 3) ? 8'h80 : 8'h3D;
            checks++;
            if (to || l !== e || (s == 3 && !sa)) begin
                errors++;
                $display("FAIL lsb_sym%0d: line=%b sd_all=%b to=%b, required %b", s, l, sa, to, e);
            end
        end
        checks++;
        if (ready_b !== 1'b1 || fifo_count_b !== 3'd0 || overflow_b !== 1'b0) begin
            errors++;
            $display("FAIL lsb_fifo: ready=%b cnt=%0d ovf=%b, required 1 0 0", ready_b, fifo_count_b, overflow_b);
        end
    endtask

    initial begin
        test_reset;
        test_idle_sync;
        test_data;
        test_burst;
        test_overflow;
        test_disable;
        test_reset_mid;
        test_lsb_first;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
